// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM stage.
// Accepts one load/store over a valid/ready request channel, waits a fixed
// number of clock edges, performs the access against a doubleword RAM and
// presents the result on a valid/ready response channel. Misaligned or
// out-of-range addresses are reported through rsp_err and never touch the RAM.
//
// Response timing: for a request accepted on edge N, the access happens on
// edge N+LATENCY and rsp_valid is high from then until the response handshake.
// The RAM clears asynchronously on reset, so it is built from flops rather
// than a block RAM.

module dmem_responder #(
    parameter int WORDSIZE = 64,
    parameter int ADDRBITS = 8,
    parameter int LATENCY  = 2      // legal range 1..15
) (
    input  logic                clk,
    input  logic                rst,        // asynchronous, active-low
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [WORDSIZE-1:0] req_addr,
    input  logic [WORDSIZE-1:0] req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORDSIZE-1:0] rsp_rdata,
    output logic                rsp_err
);

    localparam int DEPTH = 1 << ADDRBITS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // The counter holds the number of WAIT edges still to pass before the
    // access edge; the access fires on the WAIT edge that sees zero.
    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

    logic [1:0]          state_reg;
    logic [3:0]          cnt_reg;
    logic                write_reg;
    logic [WORDSIZE-1:0] addr_reg;
    logic [WORDSIZE-1:0] wdata_reg;
    logic [WORDSIZE-1:0] rdata_reg;
    logic                err_reg;

    logic [ADDRBITS-1:0] index;
    logic                addr_err;
    logic                access_now;
    logic                commit_store;

    logic [WORDSIZE-1:0] ram_rd [DEPTH];

    // Decode the latched address and detect the single access edge.
    always_comb begin
        index        = addr_reg[ADDRBITS+2:3];
        addr_err     = (addr_reg[2:0] != 3'b000) ||
                       (addr_reg[WORDSIZE-1:ADDRBITS+3] != '0);
        access_now   = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
        commit_store = access_now && write_reg && !addr_err;
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

    // RAM words: each clears on reset and captures the store data only on
    // the access edge of a legal store that targets it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ram
            logic [WORDSIZE-1:0] word_reg;

            // Per-word storage with asynchronous clear.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    word_reg <= '0;
                end else if (commit_store && (index == ADDRBITS'(gi))) begin
                    word_reg <= wdata_reg;
                end
            end

            assign ram_rd[gi] = word_reg;
        end
    endgenerate

    // Request latch, wait-state counter, access and response hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Capture everything now; request inputs may move
                        // while the access is in flight.
                        write_reg <= req_write;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        cnt_reg   <= WAIT_INIT;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        err_reg   <= addr_err;
                        rdata_reg <= (write_reg || addr_err) ? '0 : ram_rd[index];
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: a LATENCY=2 instance driven by directed and
// random load/store traffic against a word-array reference model, with a
// scoreboard monitor, plus a LATENCY=1 instance for the short-latency timing.

module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;

    logic        r1_req_valid, r1_req_ready, r1_req_write;
    logic [63:0] r1_req_addr, r1_req_wdata;
    logic        r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
    logic [63:0] r1_rsp_rdata;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model_mem [256];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          acc_edge = 0;
    bit          seen_valid = 1'b0;

    dmem_responder #(.WORDSIZE(64), .ADDRBITS(8), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.WORDSIZE(64), .ADDRBITS(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_write(r1_req_write),
        .req_addr(r1_req_addr), .req_wdata(r1_req_wdata),
        .rsp_valid(r1_rsp_valid), .rsp_ready(r1_rsp_ready),
        .rsp_rdata(r1_rsp_rdata), .rsp_err(r1_rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference model: byte-addressed view of a 256-doubleword memory.
    task automatic model(input logic w, input logic [63:0] a, input logic [63:0] d,
                         output logic [63:0] rd, output logic e);
        e  = ((a % 64'd8) != 64'd0) || (a >= 64'd2048);
        rd = 64'd0;
        if (!e) begin
            if (w) model_mem[8'(a >> 3)] = d;
            else   rd = model_mem[8'(a >> 3)];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model_mem[i] = 64'd0;
    endtask

    // Issue one request to the LATENCY=2 instance and complete its handshake.
    // stall = number of valid response cycles with rsp_ready low.
    // inject = drive a store to 0x20 while the response is stalled.
    task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input int stall_in, input bit inject);
        logic [63:0] rd;
        logic        e;
        int          n;
        int          stall;
        exp_t        x;
        stall = stall_in;
        model(w, a, d, rd, e);
        x.rdata = rd;
        x.err   = e;
        exp_q.push_back(x);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = 1'($urandom);
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) fail("accept_timeout");
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        n = 0;
        while (n < 100) begin
            if (rsp_valid) begin
                if (stall == 0) begin
                    rsp_ready = 1'b1;
                    req_valid = 1'b0;
                    break;
                end
                stall--;
                rsp_ready = 1'b0;
                if (inject) begin
                    req_valid = 1'b1;
                    req_write = 1'b1;
                    req_addr  = 64'h20;
                    req_wdata = {$urandom, $urandom} | 64'h1;
                end
            end
            @(posedge clk); #1; n++;
        end
        if (n >= 100) fail("response_timeout");
        else begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    // One access on the LATENCY=1 instance, checking its timing and data.
    task automatic run1(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [63:0] exp_rd);
        int gap;
        chk("l1_req_ready", 64'(r1_req_ready), 64'd1);
        r1_req_valid = 1'b1;
        r1_req_write = w;
        r1_req_addr  = a;
        r1_req_wdata = d;
        r1_rsp_ready = 1'b1;
        @(posedge clk); #1;
        r1_req_valid = 1'b0;
        r1_req_addr  = {$urandom, $urandom};
        gap = 0;
        do begin
            @(posedge clk); #1; gap++;
        end while (!r1_rsp_valid && gap < 20);
        chk("l1_accept_to_valid", 64'(gap), 64'd1);
        chk("l1_rdata", r1_rsp_rdata, exp_rd);
        chk("l1_err", 64'(r1_rsp_err), 64'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the DUT edge.
    always @(negedge clk) begin
        if (rst) begin
            if (req_valid && req_ready) begin
                acc_edge   = cyc + 1;
                seen_valid = 1'b0;
            end
            if (rsp_valid) begin
                chk("ready_low_in_resp", 64'(req_ready), 64'd0);
                if (!seen_valid) begin
                    chk("accept_to_valid", 64'(cyc - acc_edge), 64'(LAT));
                    seen_valid = 1'b1;
                end
                if (exp_q.size() == 0) begin
                    fail("unexpected_response");
                end else begin
                    chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                    chk("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_rdata_zero", rsp_rdata, 64'd0);
                chk("idle_err_zero", 64'(rsp_err), 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic        w;
        int          kind;

        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        r1_req_valid = 1'b0; r1_req_write = 1'b0; r1_req_addr = '0; r1_req_wdata = '0;
        r1_rsp_ready = 1'b0;
        clear_model();

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        do_req(1'b0, 64'h10, 64'd0, 0, 1'b0);
        do_req(1'b1, 64'h18, 64'h0123456789ABCDEF, 0, 1'b0);
        do_req(1'b0, 64'h18, 64'd0, 0, 1'b0);

        // Stalled load with an ignored store to 0x20 during the response.
        do_req(1'b0, 64'h18, 64'd0, 5, 1'b1);
        do_req(1'b0, 64'h20, 64'd0, 0, 1'b0);

        // Error cases leave memory untouched.
        do_req(1'b0, 64'h1C, 64'd0, 1, 1'b0);
        do_req(1'b1, 64'h800, 64'hDEADBEEFCAFEF00D, 0, 1'b0);
        do_req(1'b0, 64'h0, 64'd0, 0, 1'b0);

        // Reset during WAIT aborts an uncommitted store and clears the RAM.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h30; req_wdata = 64'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_rsp_rdata", rsp_rdata, 64'd0);
        chk("abort_rsp_err", 64'(rsp_err), 64'd0);
        exp_q.delete();
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 64'h30, 64'd0, 0, 1'b0);
        do_req(1'b0, 64'h18, 64'd0, 0, 1'b0);

        // Back-to-back store then load.
        do_req(1'b1, 64'h08, 64'd5, 0, 1'b0);
        do_req(1'b0, 64'h08, 64'd0, 0, 1'b0);

        // Random traffic over a small hot set plus error addresses.
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 6)       a = 64'($urandom_range(0, 15)) * 64'd8;
            else if (kind < 8)  a = 64'($urandom_range(0, 255)) * 64'd8 + 64'($urandom_range(1, 7));
            else if (kind == 8) a = (64'd256 + 64'($urandom_range(0, 4000))) * 64'd8;
            else                a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            w = 1'($urandom);
            do_req(w, a, {$urandom, $urandom}, int'($urandom_range(0, 3)), 1'($urandom));
        end

        // LATENCY=1 instance: store 5 then load back, one edge each.
        run1(1'b1, 64'h08, 64'd5, 64'd0);
        run1(1'b0, 64'h08, 64'd0, 64'd5);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
